// File: rtl/fib_pack_pkg.sv
// Shared FSM encoding and width helpers for the Fibonacci concatenation packer.
package fib_pack_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        COPY    = 3'd2,
        WDONE   = 3'd3,
        PUBLISH = 3'd4
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int out_w(input int data_w, input int words);
        return data_w * words;
    endfunction

    function automatic int len_w(input int data_w, input int words);
        return clog2(data_w * words + 1);
    endfunction

    function automatic int wcnt_w(input int words);
        return clog2(words + 1);
    endfunction

endpackage

// File: rtl/fib_concat_packer.sv
// Strips leading zeros from Fibonacci-coded words and packs WORDS of them
// LSB-first into one frame with a parallel top-bit marker vector.
module fib_concat_packer
    import fib_pack_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int WORDS     = 2,
    parameter int ZERO_MODE = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_W-1:0]                   in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                flush,
    output logic                                word_done,
    output logic                                frame_valid,
    output logic [out_w(DATA_W, WORDS)-1:0]     out_s,
    output logic [out_w(DATA_W, WORDS)-1:0]     out_f,
    output logic [len_w(DATA_W, WORDS)-1:0]     out_len,
    output logic [wcnt_w(WORDS)-1:0]            out_words
);

    localparam int OUT_W  = out_w(DATA_W, WORDS);
    localparam int LEN_W  = len_w(DATA_W, WORDS);
    localparam int WCNT_W = wcnt_w(WORDS);
    localparam int IDX_W  = clog2(DATA_W);
    localparam int POS_W  = clog2(OUT_W);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    m_q, m_d;
    logic [OUT_W-1:0]    s_q, s_d;
    logic [OUT_W-1:0]    f_q, f_d;
    logic [LEN_W-1:0]    o_q, o_d;
    logic [WCNT_W-1:0]   wc_q, wc_d;
    logic                flush_q, flush_d;
    logic                word_done_q, word_done_d;
    logic                frame_valid_q, frame_valid_d;
    logic [OUT_W-1:0]    out_s_q, out_s_d;
    logic [OUT_W-1:0]    out_f_q, out_f_d;
    logic [LEN_W-1:0]    out_len_q, out_len_d;
    logic [WCNT_W-1:0]   out_words_q, out_words_d;

    logic                handshake;
    logic                publish;
    logic [WCNT_W-1:0]   pub_words;
    logic [POS_W-1:0]    o_pos;
    logic [POS_W-1:0]    bit_pos;

    assign in_ready  = (state_q == IDLE);
    assign handshake = in_valid & in_ready;
    // o only reaches OUT_W once a frame is complete, never while a word is being packed
    assign o_pos     = POS_W'(o_q);
    assign bit_pos   = o_pos + POS_W'(idx_q);

    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        idx_d         = idx_q;
        m_d           = m_q;
        s_d           = s_q;
        f_d           = f_q;
        o_d           = o_q;
        wc_d          = wc_q;
        out_s_d       = out_s_q;
        out_f_d       = out_f_q;
        out_len_d     = out_len_q;
        out_words_d   = out_words_q;
        word_done_d   = 1'b0;
        frame_valid_d = 1'b0;
        publish       = 1'b0;
        pub_words     = wc_q;
        // A flush that cannot act right away is held until the current word finishes
        flush_d       = flush_q | (flush & ~((state_q == IDLE) & ~handshake));

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    word_d  = in_data;
                    idx_d   = IDX_W'(DATA_W - 1);
                    state_d = SCAN;
                end else if (flush && (wc_q != '0)) begin
                    state_d = PUBLISH;
                end
            end
            SCAN: begin
                if (word_q == '0) begin
                    if (ZERO_MODE != 0) begin
                        s_d[o_pos] = 1'b1;
                        o_d        = o_q + LEN_W'(1);
                    end
                    state_d = WDONE;
                end else if (word_q[idx_q]) begin
                    s_d[bit_pos] = 1'b1;
                    m_d          = idx_q;
                    state_d      = COPY;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            COPY: begin
                f_d[bit_pos] = word_q[idx_q];
                if (idx_q == '0) begin
                    o_d     = o_q + LEN_W'(m_q) + LEN_W'(1);
                    state_d = WDONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            WDONE: begin
                pub_words = wc_q + 1'b1;
                if ((wc_q == WCNT_W'(WORDS - 1)) || flush_q || flush) begin
                    publish = 1'b1;
                end else begin
                    wc_d        = wc_q + 1'b1;
                    word_done_d = 1'b1;
                end
                state_d = IDLE;
            end
            PUBLISH: begin
                publish = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (publish) begin
            out_s_d       = s_q;
            out_f_d       = f_q;
            out_len_d     = o_q;
            out_words_d   = pub_words;
            frame_valid_d = 1'b1;
            s_d           = '0;
            f_d           = '0;
            o_d           = '0;
            wc_d          = '0;
            flush_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            word_q        <= '0;
            idx_q         <= '0;
            m_q           <= '0;
            s_q           <= '0;
            f_q           <= '0;
            o_q           <= '0;
            wc_q          <= '0;
            flush_q       <= 1'b0;
            word_done_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            out_s_q       <= '0;
            out_f_q       <= '0;
            out_len_q     <= '0;
            out_words_q   <= '0;
        end else begin
            state_q       <= state_d;
            word_q        <= word_d;
            idx_q         <= idx_d;
            m_q           <= m_d;
            s_q           <= s_d;
            f_q           <= f_d;
            o_q           <= o_d;
            wc_q          <= wc_d;
            flush_q       <= flush_d;
            word_done_q   <= word_done_d;
            frame_valid_q <= frame_valid_d;
            out_s_q       <= out_s_d;
            out_f_q       <= out_f_d;
            out_len_q     <= out_len_d;
            out_words_q   <= out_words_d;
        end
    end

    assign word_done   = word_done_q;
    assign frame_valid = frame_valid_q;
    assign out_s       = out_s_q;
    assign out_f       = out_f_q;
    assign out_len     = out_len_q;
    assign out_words   = out_words_q;

endmodule
